// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, exception codes, writeback FSM states.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ECODE_W = 6;

  // Exception codes carried down the pipeline alongside ms_ex.
  localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
  localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;
  localparam logic [ECODE_W-1:0] ECODE_IPE = 6'h0E;

  // Writeback stage: normal operation, or the single dead cycle after a commit flush.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: final pipeline register, regfile write port, ID bypass source,
// exception/ertn commit pulses and the retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN    = cpu_pkg::XLEN,
  parameter int unsigned REG_AW  = cpu_pkg::REG_AW,
  parameter int unsigned ECODE_W = cpu_pkg::ECODE_W
) (
  input  logic               clk,
  input  logic               reset,
  // MEM -> WB handshake and payload
  input  logic               ms_to_ws_valid,
  output logic               ws_allowin,
  input  logic [XLEN-1:0]    ms_pc,
  input  logic               ms_gr_we,
  input  logic [REG_AW-1:0]  ms_dest,
  input  logic [XLEN-1:0]    ms_result,
  input  logic               ms_ex,
  input  logic [ECODE_W-1:0] ms_ecode,
  input  logic               ms_ertn,
  // Regfile write port
  output logic [3:0]         rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  // ID-stage bypass
  output logic               ws_fwd_valid,
  output logic [REG_AW-1:0]  ws_fwd_dest,
  output logic [XLEN-1:0]    ws_fwd_data,
  // Commit flushes
  output logic               ws_ex_flush,
  output logic [XLEN-1:0]    ws_ex_pc,
  output logic [ECODE_W-1:0] ws_ex_ecode,
  output logic               ws_ertn_flush,
  // Retire statistics and trace
  output logic [31:0]        retire_cnt,
  output logic [XLEN-1:0]    debug_wb_pc,
  output logic [3:0]         debug_wb_rf_we,
  output logic [REG_AW-1:0]  debug_wb_rf_wnum,
  output logic [XLEN-1:0]    debug_wb_rf_wdata
);

  wb_state_e          state_q, state_d;
  logic               ws_valid_q, ws_valid_d;
  logic [XLEN-1:0]    ws_pc_q, ws_pc_d;
  logic               ws_gr_we_q, ws_gr_we_d;
  logic [REG_AW-1:0]  ws_dest_q, ws_dest_d;
  logic [XLEN-1:0]    ws_result_q, ws_result_d;
  logic               ws_ex_q, ws_ex_d;
  logic [ECODE_W-1:0] ws_ecode_q, ws_ecode_d;
  logic               ws_ertn_q, ws_ertn_d;
  logic [31:0]        retire_cnt_q, retire_cnt_d;

  logic               ws_commit_ok;
  logic               ws_we;

  // Commit FSM: pulse the flush for the committing cycle, then hold one FLUSH cycle.
  always_comb begin
    state_d       = state_q;
    ws_allowin    = 1'b0;
    ws_ex_flush   = 1'b0;
    ws_ertn_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        ws_allowin = !(ws_valid_q && (ws_ex_q || ws_ertn_q));
        if (ws_valid_q && ws_ex_q) begin
          // Exception wins over ertn when both are flagged.
          ws_ex_flush = 1'b1;
          state_d     = FLUSH;
        end else if (ws_valid_q && ws_ertn_q) begin
          ws_ertn_flush = 1'b1;
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Pipeline register: accept from MEM when open; otherwise the slot is emptied.
  always_comb begin
    ws_valid_d  = ws_valid_q;
    ws_pc_d     = ws_pc_q;
    ws_gr_we_d  = ws_gr_we_q;
    ws_dest_d   = ws_dest_q;
    ws_result_d = ws_result_q;
    ws_ex_d     = ws_ex_q;
    ws_ecode_d  = ws_ecode_q;
    ws_ertn_d   = ws_ertn_q;
    if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        ws_pc_d     = ms_pc;
        ws_gr_we_d  = ms_gr_we;
        ws_dest_d   = ms_dest;
        ws_result_d = ms_result;
        ws_ex_d     = ms_ex;
        ws_ecode_d  = ms_ecode;
        ws_ertn_d   = ms_ertn;
      end
    end else begin
      // allowin is low only in the commit cycle or the FLUSH cycle; both retire the
      // current slot so FLUSH never sees a valid instruction and ms data is dropped.
      ws_valid_d = 1'b0;
    end
  end

  // Retired-instruction counter: everything that leaves WB without an exception.
  always_comb begin
    ws_commit_ok = ws_valid_q && !ws_ex_q;
    retire_cnt_d = retire_cnt_q;
    if (ws_commit_ok) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // State, pipeline and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      ws_valid_q   <= 1'b0;
      ws_pc_q      <= '0;
      ws_gr_we_q   <= 1'b0;
      ws_dest_q    <= '0;
      ws_result_q  <= '0;
      ws_ex_q      <= 1'b0;
      ws_ecode_q   <= '0;
      ws_ertn_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ws_valid_q   <= ws_valid_d;
      ws_pc_q      <= ws_pc_d;
      ws_gr_we_q   <= ws_gr_we_d;
      ws_dest_q    <= ws_dest_d;
      ws_result_q  <= ws_result_d;
      ws_ex_q      <= ws_ex_d;
      ws_ecode_q   <= ws_ecode_d;
      ws_ertn_q    <= ws_ertn_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Write port, bypass and trace are combinational views of the latched slot.
  always_comb begin
    ws_we             = ws_valid_q && ws_gr_we_q && !ws_ex_q && !ws_ertn_q;
    rf_we             = {4{ws_we}};
    rf_waddr          = ws_dest_q;
    rf_wdata          = ws_result_q;
    ws_fwd_valid      = ws_we && (ws_dest_q != '0);
    ws_fwd_dest       = ws_dest_q;
    ws_fwd_data       = ws_result_q;
    ws_ex_pc          = ws_pc_q;
    ws_ex_ecode       = ws_ecode_q;
    retire_cnt        = retire_cnt_q;
    debug_wb_pc       = ws_pc_q;
    debug_wb_rf_we    = {4{ws_we}};
    debug_wb_rf_wnum  = ws_dest_q;
    debug_wb_rf_wdata = ws_result_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: writes, bypass, exception/ertn commit, bubbles,
// asynchronous reset and counter wrap.
module tb_wb_stage;
  import cpu_pkg::*;

  logic               clk;
  logic               reset;
  logic               ms_to_ws_valid;
  logic               ws_allowin;
  logic [31:0]        ms_pc;
  logic               ms_gr_we;
  logic [4:0]         ms_dest;
  logic [31:0]        ms_result;
  logic               ms_ex;
  logic [5:0]         ms_ecode;
  logic               ms_ertn;
  logic [3:0]         rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               ws_fwd_valid;
  logic [4:0]         ws_fwd_dest;
  logic [31:0]        ws_fwd_data;
  logic               ws_ex_flush;
  logic [31:0]        ws_ex_pc;
  logic [5:0]         ws_ex_ecode;
  logic               ws_ertn_flush;
  logic [31:0]        retire_cnt;
  logic [31:0]        debug_wb_pc;
  logic [3:0]         debug_wb_rf_we;
  logic [4:0]         debug_wb_rf_wnum;
  logic [31:0]        debug_wb_rf_wdata;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage #(.XLEN(32), .REG_AW(5), .ECODE_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result),
    .ms_ex             (ms_ex),
    .ms_ecode          (ms_ecode),
    .ms_ertn           (ms_ertn),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .ws_ex_flush       (ws_ex_flush),
    .ws_ex_pc          (ws_ex_pc),
    .ws_ex_ecode       (ws_ex_ecode),
    .ws_ertn_flush     (ws_ertn_flush),
    .retire_cnt        (retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] dest, input logic [31:0] res,
                       input logic ex, input logic [5:0] ecode, input logic ertn);
    ms_to_ws_valid = v;
    ms_pc          = pc;
    ms_gr_we       = we;
    ms_dest        = dest;
    ms_result      = res;
    ms_ex          = ex;
    ms_ecode       = ecode;
    ms_ertn        = ertn;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check("rst_allowin",   {31'd0, ws_allowin},    32'd1);
    check("rst_rf_we",     {28'd0, rf_we},         32'd0);
    check("rst_cnt",       retire_cnt,             32'd0);
    check("rst_ex_flush",  {31'd0, ws_ex_flush},   32'd0);
    check("rst_ertn",      {31'd0, ws_ertn_flush}, 32'd0);
    check("rst_fwd_valid", {31'd0, ws_fwd_valid},  32'd0);
    check("rst_dbg_pc",    debug_wb_pc,            32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back writes r5, r6, r0
    drive(1'b1, 32'h1C00_0000, 1'b1, 5'd5, 32'h11, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    check("b2b0_we",       {28'd0, rf_we},        32'hF);
    check("b2b0_waddr",    {27'd0, rf_waddr},     32'd5);
    check("b2b0_wdata",    rf_wdata,              32'h11);
    check("b2b0_fwd",      {31'd0, ws_fwd_valid}, 32'd1);
    check("b2b0_fwd_data", ws_fwd_data,           32'h11);
    check("b2b0_dbg_pc",   debug_wb_pc,           32'h1C00_0000);
    drive(1'b1, 32'h1C00_0004, 1'b1, 5'd6, 32'h22, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    check("b2b1_we",       {28'd0, rf_we},        32'hF);
    check("b2b1_waddr",    {27'd0, rf_waddr},     32'd6);
    check("b2b1_fwd",      {31'd0, ws_fwd_valid}, 32'd1);
    check("b2b1_fwd_dest", {27'd0, ws_fwd_dest},  32'd6);
    check("b2b1_cnt",      retire_cnt,            32'd1);
    drive(1'b1, 32'h1C00_0008, 1'b1, 5'd0, 32'h33, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    check("b2b2_we",       {28'd0, rf_we},          32'hF);
    check("b2b2_waddr",    {27'd0, rf_waddr},       32'd0);
    check("b2b2_fwd",      {31'd0, ws_fwd_valid},   32'd0);
    check("b2b2_dbg_we",   {28'd0, debug_wb_rf_we}, 32'hF);
    check("b2b2_dbg_data", debug_wb_rf_wdata,       32'h33);
    check("b2b2_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd0);
    idle();
    @(negedge clk);
    check("b2b_cnt",       retire_cnt,            32'd3);
    check("b2b_idle_we",   {28'd0, rf_we},        32'd0);

    // Exception with a younger instruction pending behind it
    drive(1'b1, 32'h1C00_0010, 1'b1, 5'd4, 32'h44, 1'b1, ECODE_SYS, 1'b0);
    @(negedge clk);
    check("ex_rf_we",      {28'd0, rf_we},        32'd0);
    check("ex_flush",      {31'd0, ws_ex_flush},  32'd1);
    check("ex_pc",         ws_ex_pc,              32'h1C00_0010);
    check("ex_ecode",      {26'd0, ws_ex_ecode},  32'h0B);
    check("ex_allowin0",   {31'd0, ws_allowin},   32'd0);
    check("ex_fwd",        {31'd0, ws_fwd_valid}, 32'd0);
    drive(1'b1, 32'h1C00_0014, 1'b1, 5'd7, 32'h77, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    check("ex_flush_end",  {31'd0, ws_ex_flush},  32'd0);
    check("ex_allowin1",   {31'd0, ws_allowin},   32'd0);
    check("ex_fl_rf_we",   {28'd0, rf_we},        32'd0);
    check("ex_fl_cnt",     retire_cnt,            32'd3);
    @(negedge clk);
    check("ex_reopen",     {31'd0, ws_allowin},   32'd1);
    check("ex_pend_we",    {28'd0, rf_we},        32'd0);
    check("ex_pend_fwd",   {31'd0, ws_fwd_valid}, 32'd0);
    check("ex_cnt",        retire_cnt,            32'd3);
    idle();

    // ex and ertn together: only the exception commits
    drive(1'b1, 32'h1C00_0020, 1'b0, 5'd0, 32'h0, 1'b1, ECODE_BRK, 1'b1);
    @(negedge clk);
    check("exertn_ex",     {31'd0, ws_ex_flush},   32'd1);
    check("exertn_ertn",   {31'd0, ws_ertn_flush}, 32'd0);
    check("exertn_ecode",  {26'd0, ws_ex_ecode},   32'h0C);
    idle();
    @(negedge clk);
    check("exertn_fl_ex",  {31'd0, ws_ex_flush},   32'd0);
    check("exertn_fl_er",  {31'd0, ws_ertn_flush}, 32'd0);
    @(negedge clk);
    check("exertn_open",   {31'd0, ws_allowin},    32'd1);
    // plain ertn
    drive(1'b1, 32'h1C00_0030, 1'b0, 5'd0, 32'h0, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    check("ertn_pulse",    {31'd0, ws_ertn_flush}, 32'd1);
    check("ertn_no_ex",    {31'd0, ws_ex_flush},   32'd0);
    check("ertn_allowin",  {31'd0, ws_allowin},    32'd0);
    check("ertn_rf_we",    {28'd0, rf_we},         32'd0);
    check("ertn_cnt_pre",  retire_cnt,             32'd3);
    idle();
    @(negedge clk);
    check("ertn_pulse_end", {31'd0, ws_ertn_flush}, 32'd0);
    check("ertn_cnt",       retire_cnt,             32'd4);
    @(negedge clk);
    check("ertn_reopen",    {31'd0, ws_allowin},    32'd1);
    check("ertn_cnt_hold",  retire_cnt,             32'd4);

    // Bubbles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bub_we",      {28'd0, rf_we},        32'd0);
      check("bub_fwd",     {31'd0, ws_fwd_valid}, 32'd0);
      check("bub_cnt",     retire_cnt,            32'd4);
      check("bub_allowin", {31'd0, ws_allowin},   32'd1);
    end

    // Asynchronous reset in the middle of an exception commit
    drive(1'b1, 32'h1C00_0040, 1'b1, 5'd9, 32'h99, 1'b1, ECODE_ADE, 1'b0);
    @(negedge clk);
    check("mid_ex_flush",  {31'd0, ws_ex_flush},  32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ex_flush", {31'd0, ws_ex_flush},  32'd0);
    check("arst_allowin",  {31'd0, ws_allowin},   32'd1);
    check("arst_cnt",      retire_cnt,            32'd0);
    check("arst_rf_we",    {28'd0, rf_we},        32'd0);
    check("arst_ex_pc",    ws_ex_pc,              32'd0);
    check("arst_dbg_pc",   debug_wb_pc,           32'd0);
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Counter wrap
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    drive(1'b1, 32'h1C00_0050, 1'b1, 5'd3, 32'h55, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    check("wrap_pre",      retire_cnt,            32'hFFFF_FFFF);
    check("wrap_we",       {28'd0, rf_we},        32'hF);
    idle();
    @(negedge clk);
    check("wrap_post",     retire_cnt,            32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
